// File: rtl/aud_pkg.sv
// Shared types and default widths for the audio playback controller.
package aud_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned SPEED_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH      = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_PAUSE      = 2'd3
    } state_t;

endpackage

// File: rtl/aud_edge_det.sv
// Registered falling-edge detector for the DAC frame clock.
module aud_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic hist;

    // History of din, and a one-cycle pulse when it goes 1 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= 1'b1;
            fall <= 1'b0;
        end else begin
            hist <= din;
            fall <= hist & ~din;
        end
    end

endmodule

// File: rtl/aud_play_ctrl.sv
// Playback controller: fetches samples from SRAM once per DAC frame,
// with fast (skip) / slow (repeat) rate control, pause/resume and stop.
module aud_play_ctrl
    import aud_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic               i_bclk,
    input  logic               i_rst_n,
    input  logic               i_daclrck,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic               i_fast,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [ADDR_W-1:0]  i_end_addr,
    output logic               o_sram_req,
    input  logic               i_sram_ack,
    input  logic [DATA_W-1:0]  i_sram_data,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic [DATA_W-1:0]  o_dac_data,
    output logic               o_player_en,
    output logic [1:0]         o_state,
    output logic               o_done
);

    state_t             state;
    logic [SPEED_W-1:0] rep_cnt;
    logic               pause_lat;
    logic               frame_ev;
    logic [ADDR_W:0]    step_c;
    logic [ADDR_W:0]    sum_c;
    logic               past_end_c;

    aud_edge_det u_edge (
        .clk   (i_bclk),
        .rst_n (i_rst_n),
        .din   (i_daclrck),
        .fall  (frame_ev)
    );

    // Candidate next address, one bit wider so a wrap shows up as a carry.
    always_comb begin
        step_c     = i_fast ? ((ADDR_W+1)'(i_speed) + (ADDR_W+1)'(1)) : (ADDR_W+1)'(1);
        sum_c      = {1'b0, o_sram_addr} + step_c;
        past_end_c = sum_c[ADDR_W] | (sum_c[ADDR_W-1:0] > i_end_addr);
    end

    assign o_state = state;

    // Playback FSM with registered outputs; stop overrides everything.
    always_ff @(posedge i_bclk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_sram_req  <= 1'b0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_player_en <= 1'b0;
            o_done      <= 1'b0;
            rep_cnt     <= '0;
            pause_lat   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_stop) begin
                state       <= ST_IDLE;
                o_sram_req  <= 1'b0;
                o_sram_addr <= '0;
                o_player_en <= 1'b0;
                pause_lat   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        o_player_en <= 1'b0;
                        if (i_start && !i_pause) begin
                            o_sram_addr <= '0;
                            rep_cnt     <= '0;
                            pause_lat   <= 1'b0;
                            o_sram_req  <= 1'b1;
                            state       <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // A pause never abandons the handshake; it waits for ack.
                        if (i_sram_ack) begin
                            o_dac_data <= i_sram_data;
                            o_sram_req <= 1'b0;
                            if (pause_lat || i_pause) begin
                                state       <= ST_PAUSE;
                                o_player_en <= 1'b0;
                                pause_lat   <= 1'b0;
                            end else begin
                                state       <= ST_WAIT_FRAME;
                                o_player_en <= 1'b1;
                            end
                        end else if (i_pause) begin
                            pause_lat <= 1'b1;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (i_pause) begin
                            state       <= ST_PAUSE;
                            o_player_en <= 1'b0;
                        end else if (frame_ev) begin
                            if (i_fast || (rep_cnt >= i_speed)) begin
                                rep_cnt <= '0;
                                if (past_end_c) begin
                                    o_done      <= 1'b1;
                                    o_player_en <= 1'b0;
                                    state       <= ST_IDLE;
                                end else begin
                                    o_sram_addr <= sum_c[ADDR_W-1:0];
                                    o_sram_req  <= 1'b1;
                                    state       <= ST_FETCH;
                                end
                            end else begin
                                rep_cnt <= rep_cnt + SPEED_W'(1);
                            end
                        end
                    end
                    ST_PAUSE: begin
                        o_player_en <= 1'b0;
                        if (i_start && !i_pause) begin
                            state       <= ST_WAIT_FRAME;
                            o_player_en <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
